cache_data_array: RTL and testbench

- Parametrised set-associative cache data store: 2^INDEX_WIDTH sets × 2^WAY_WIDTH ways × 2^OFFSET_WIDTH words per line, WORD_WIDTH bits per word.
- Sits between the cache controller (hit reads, byte-masked store writes) and the refill path (line-fill bursts from the next memory level).
- Adds the following to the data array:
  - registered read port with valid flag;
  - byte-enable writes;
  - burst line-fill FSM;
  - sequenced post-reset clear.

---
 rtl/cache_data_array.sv | 159 +++++++++++++++
 tb/tb_cache_data_array.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_data_array.sv
// rtl/cache_data_array.sv - set-associative cache data store with byte-masked stores, line-fill FSM and post-reset clear
// Optional CDA_WR_BYPASS_EN: a read colliding with a same-cycle store/fill beat returns the post-write word.
module cache_data_array #(
   parameter int INDEX_WIDTH  = 6,
   parameter int WAY_WIDTH    = 3,
   parameter int OFFSET_WIDTH = 2,
   parameter int WORD_WIDTH   = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   output logic                      init_busy,
   input  logic                      rd_req,
   input  logic [INDEX_WIDTH-1:0]    rd_index,
   input  logic [WAY_WIDTH-1:0]      rd_way,
   input  logic [OFFSET_WIDTH-1:0]   rd_offset,
   output logic                      rd_valid,
   output logic [WORD_WIDTH-1:0]     rd_data,
   input  logic                      wr_req,
   output logic                      wr_ready,
   input  logic [INDEX_WIDTH-1:0]    wr_index,
   input  logic [WAY_WIDTH-1:0]      wr_way,
   input  logic [OFFSET_WIDTH-1:0]   wr_offset,
   input  logic [WORD_WIDTH-1:0]     wr_data,
   input  logic [WORD_WIDTH/8-1:0]   wr_be,
   input  logic                      fill_start,
   input  logic [INDEX_WIDTH-1:0]    fill_index,
   input  logic [WAY_WIDTH-1:0]      fill_way,
   input  logic                      fill_valid,
   input  logic [WORD_WIDTH-1:0]     fill_data,
   output logic                      fill_ready,
   output logic                      fill_done
);
   localparam int BYTES     = WORD_WIDTH / 8;
   localparam int LINE_BITS = WAY_WIDTH + OFFSET_WIDTH;
   localparam int ADDR_W    = INDEX_WIDTH + LINE_BITS;
   localparam int DEPTH     = 1 << ADDR_W;
   localparam int SET_WORDS = 1 << LINE_BITS;
   localparam logic [INDEX_WIDTH-1:0]  LAST_SET  = '1;
   localparam logic [OFFSET_WIDTH-1:0] LAST_BEAT = '1;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} fill_state_t;

   logic [WORD_WIDTH-1:0]   r_mem [DEPTH];
   fill_state_t             r_state;
   logic                    r_init_busy;
   logic [INDEX_WIDTH-1:0]  r_clr_cnt;
   logic                    r_rd_valid;
   logic [WORD_WIDTH-1:0]   r_rd_data;
   logic                    r_fill_ready;
   logic                    r_fill_done;
   logic [INDEX_WIDTH-1:0]  r_fill_index;
   logic [WAY_WIDTH-1:0]    r_fill_way;
   logic [OFFSET_WIDTH-1:0] r_beat_cnt;

   logic [ADDR_W-1:0]       w_rd_addr;
   logic [ADDR_W-1:0]       w_wr_addr;
   logic [ADDR_W-1:0]       w_fill_addr;
   logic                    w_rd_acc;
   logic                    w_wr_acc;
   logic                    w_beat;
   logic [WORD_WIDTH-1:0]   w_rd_word;

   assign w_rd_addr   = {rd_index, rd_way, rd_offset};
   assign w_wr_addr   = {wr_index, wr_way, wr_offset};
   assign w_fill_addr = {r_fill_index, r_fill_way, r_beat_cnt};

   // Handshake readies are gated by reset so nothing is accepted on a resetting edge.
   assign fill_ready = r_fill_ready && !reset;
   assign wr_ready   = !reset && !r_init_busy && !(fill_valid && fill_ready);
   assign w_beat     = fill_valid && fill_ready;
   assign w_wr_acc   = wr_req && wr_ready;
   assign w_rd_acc   = rd_req && !r_init_busy;

   assign init_busy = r_init_busy;
   assign rd_valid  = r_rd_valid;
   assign rd_data   = r_rd_data;
   assign fill_done = r_fill_done;

   always_comb begin
      w_rd_word = r_mem[w_rd_addr];
`ifdef CDA_WR_BYPASS_EN
      if (w_beat && (w_fill_addr == w_rd_addr)) begin
         w_rd_word = fill_data;
      end else if (w_wr_acc && (w_wr_addr == w_rd_addr)) begin
         for (int k = 0; k < BYTES; k++) begin
            if (wr_be[k]) w_rd_word[8*k +: 8] = wr_data[8*k +: 8];
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (r_init_busy) begin
            for (int i = 0; i < SET_WORDS; i++) begin
               r_mem[{r_clr_cnt, LINE_BITS'(i)}] <= '0;
            end
         end else if (w_beat) begin
            r_mem[w_fill_addr] <= fill_data;
         end else if (w_wr_acc) begin
            for (int k = 0; k < BYTES; k++) begin
               if (wr_be[k]) r_mem[w_wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_init_busy <= 1'b1;
         r_clr_cnt   <= '0;
         r_rd_valid  <= 1'b0;
         r_rd_data   <= '0;
      end else begin
         if (r_init_busy) begin
            if (r_clr_cnt == LAST_SET) r_init_busy <= 1'b0;
            r_clr_cnt <= r_clr_cnt + 1'b1;
         end
         r_rd_valid <= w_rd_acc;
         if (w_rd_acc) r_rd_data <= w_rd_word;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_fill_ready <= 1'b0;
         r_fill_done  <= 1'b0;
         r_fill_index <= '0;
         r_fill_way   <= '0;
         r_beat_cnt   <= '0;
      end else begin
         r_fill_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (fill_start && !r_init_busy) begin
                  r_fill_index <= fill_index;
                  r_fill_way   <= fill_way;
                  r_beat_cnt   <= '0;
                  r_fill_ready <= 1'b1;
                  r_state      <= S_FILL;
               end
            end
            S_FILL: begin
               if (w_beat) begin
                  r_beat_cnt <= r_beat_cnt + 1'b1;
                  if (r_beat_cnt == LAST_BEAT) begin
                     r_fill_ready <= 1'b0;
                     r_fill_done  <= 1'b1;
                     r_state      <= S_DONE;
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cache_data_array.sv
// tb/tb_cache_data_array.sv - scoreboard bench for cache_data_array against a flat-array reference model
module tb_cache_data_array;
   logic        clk;
   logic        reset;
   logic        init_busy;
   logic        rd_req;
   logic [5:0]  rd_index;
   logic [2:0]  rd_way;
   logic [1:0]  rd_offset;
   logic        rd_valid;
   logic [63:0] rd_data;
   logic        wr_req;
   logic        wr_ready;
   logic [5:0]  wr_index;
   logic [2:0]  wr_way;
   logic [1:0]  wr_offset;
   logic [63:0] wr_data;
   logic [7:0]  wr_be;
   logic        fill_start;
   logic [5:0]  fill_index;
   logic [2:0]  fill_way;
   logic        fill_valid;
   logic [63:0] fill_data;
   logic        fill_ready;
   logic        fill_done;

   cache_data_array dut (
      .clk(clk), .reset(reset), .init_busy(init_busy),
      .rd_req(rd_req), .rd_index(rd_index), .rd_way(rd_way), .rd_offset(rd_offset),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .wr_req(wr_req), .wr_ready(wr_ready), .wr_index(wr_index), .wr_way(wr_way),
      .wr_offset(wr_offset), .wr_data(wr_data), .wr_be(wr_be),
      .fill_start(fill_start), .fill_index(fill_index), .fill_way(fill_way),
      .fill_valid(fill_valid), .fill_data(fill_data), .fill_ready(fill_ready),
      .fill_done(fill_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] m_mem [2048];
   logic [63:0] exp_q [$];
   bit          m_busy;
   int          m_clr;
   bit          m_fr;
   bit          m_fd;
   int          m_fidx, m_fway, m_beat;
   bit          m_last_wr_acc;

   function automatic int maddr(input int idx, input int way, input int off);
      return (idx * 8 + way) * 4 + off;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_rd_valid", 64'd1, 64'd0);
            else chk("rd_data", rd_data, exp_q.pop_front());
         end
      end
   end

   task automatic idle();
      rd_req = 0; wr_req = 0; fill_start = 0; fill_valid = 0;
   endtask

   // One clock: check handshake outputs, advance the reference model, then cross the edge.
   task automatic tick();
      bit fr_e, wrr_e, rd_acc, beat, wr_acc, nd;
      int ra, wa;
      logic [63:0] rexp;
      #1;
      fr_e  = m_fr && !reset;
      wrr_e = !reset && !m_busy && !(fill_valid && fr_e);
      chk("init_busy", {63'd0, init_busy}, {63'd0, m_busy});
      chk("fill_ready", {63'd0, fill_ready}, {63'd0, fr_e});
      chk("wr_ready", {63'd0, wr_ready}, {63'd0, wrr_e});
      chk("fill_done", {63'd0, fill_done}, {63'd0, m_fd});
      m_last_wr_acc = 0;
      if (reset) begin
         m_busy = 1; m_clr = 0; m_fr = 0; m_fd = 0;
      end else begin
         rd_acc = rd_req && !m_busy;
         beat   = fill_valid && fr_e;
         wr_acc = wr_req && wrr_e;
         m_last_wr_acc = wr_acc;
         ra = maddr(rd_index, rd_way, rd_offset);
         rexp = m_mem[ra];
         if (beat) m_mem[maddr(m_fidx, m_fway, m_beat)] = fill_data;
         if (wr_acc) begin
            wa = maddr(wr_index, wr_way, wr_offset);
            for (int k = 0; k < 8; k++) if (wr_be[k]) m_mem[wa][8*k +: 8] = wr_data[8*k +: 8];
         end
`ifdef CDA_WR_BYPASS_EN
         rexp = m_mem[ra];
`endif
         if (rd_acc) exp_q.push_back(rexp);
         nd = 0;
         if (m_fr) begin
            if (beat) begin
               m_beat++;
               if (m_beat == 4) begin m_fr = 0; nd = 1; end
            end
         end else if (!m_fd && fill_start && !m_busy) begin
            m_fr = 1; m_fidx = fill_index; m_fway = fill_way; m_beat = 0;
         end
         m_fd = nd;
         if (m_busy) begin
            for (int i = 0; i < 32; i++) m_mem[m_clr * 32 + i] = 64'd0;
            m_clr++;
            if (m_clr == 64) m_busy = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input int idx, input int way, input int off);
      rd_req = 1; rd_index = 6'(idx); rd_way = 3'(way); rd_offset = 2'(off);
      tick();
      rd_req = 0;
   endtask

   task automatic st(input int idx, input int way, input int off, input logic [63:0] d, input logic [7:0] be);
      wr_req = 1; wr_index = 6'(idx); wr_way = 3'(way); wr_offset = 2'(off); wr_data = d; wr_be = be;
      tick();
      wr_req = 0;
   endtask

   task automatic run_clear();
      int busy_cnt;
      busy_cnt = 0;
      for (int c = 0; c < 100 && m_busy; c++) begin
         rd_req = 1; wr_req = 1; fill_start = 1; wr_be = 8'hFF;
         rd_index = 6'($urandom); wr_index = 6'($urandom); fill_index = 6'($urandom);
         if (init_busy) busy_cnt++;
         tick();
      end
      idle();
      chk("clear_cycles", 64'(busy_cnt), 64'd64);
   endtask

   task automatic beat(input logic [63:0] d);
      fill_valid = 1; fill_data = d;
      tick();
      fill_valid = 0;
   endtask

   initial begin
      idle();
      reset = 1;
      rd_index = 0; rd_way = 0; rd_offset = 0;
      wr_index = 0; wr_way = 0; wr_offset = 0; wr_data = 0; wr_be = 0;
      fill_index = 0; fill_way = 0; fill_data = 0;
      for (int i = 0; i < 2048; i++) m_mem[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
      m_busy = 1; m_clr = 0; m_fr = 0; m_fd = 0; m_fidx = 0; m_fway = 0; m_beat = 0;
      @(posedge clk); #1;
      chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
      chk("rst_rd_data", rd_data, 64'd0);
      chk("rst_init_busy", {63'd0, init_busy}, 64'd1);
      tick();
      reset = 0;
      run_clear();

      rd(0, 0, 0); rd(63, 7, 3); rd(5, 3, 2);
      st(5, 3, 2, 64'h1122334455667788, 8'hFF);
      st(5, 3, 2, 64'h00000000000000AA, 8'h01);
      st(5, 3, 2, 64'hFFFFFFFFFFFFFFFF, 8'h00);
      rd(5, 3, 2);

      fill_start = 1; fill_index = 10; fill_way = 7; tick(); fill_start = 0;
      beat(64'hA0); beat(64'hA1); tick(); beat(64'hA2); beat(64'hA3);
      tick(); tick();
      for (int o = 0; o < 4; o++) rd(10, 7, o);

      fill_start = 1; fill_index = 20; fill_way = 1; tick(); fill_start = 0;
      fill_valid = 1; fill_data = 64'hB0;
      wr_req = 1; wr_index = 21; wr_way = 1; wr_offset = 3; wr_data = 64'h77; wr_be = 8'hFF;
      tick();
      fill_valid = 0;
      for (int c = 0; c < 4 && wr_req; c++) begin
         tick();
         if (m_last_wr_acc) wr_req = 0;
      end
      wr_req = 0;
      beat(64'hB1); beat(64'hB2); beat(64'hB3); tick(); tick();
      rd(20, 1, 0); rd(20, 1, 3); rd(21, 1, 3);

      st(30, 0, 1, 64'h33, 8'hFF);
      rd_req = 1; rd_index = 30; rd_way = 0; rd_offset = 1;
      st(30, 0, 1, 64'h55, 8'hFF);
      rd_req = 0;
      rd(30, 0, 1);

      fill_start = 1; fill_index = 40; fill_way = 2; tick(); fill_start = 0;
      beat(64'hC0); beat(64'hC1);
      reset = 1; tick(); reset = 0;
      run_clear();
      rd(40, 2, 0); rd(40, 2, 1);
      fill_start = 1; fill_index = 40; fill_way = 2; tick(); fill_start = 0;
      chk("refill_ready", {63'd0, fill_ready}, 64'd1);
      beat(64'hD0); beat(64'hD1); beat(64'hD2); beat(64'hD3); tick(); tick();
      rd(40, 2, 3);

      for (int n = 0; n < 400; n++) begin
         rd_req = 1'($urandom); rd_index = 6'($urandom_range(0, 3)); rd_way = 3'($urandom_range(0, 1));
         rd_offset = 2'($urandom);
         wr_req = 1'($urandom); wr_index = 6'($urandom_range(0, 3)); wr_way = 3'($urandom_range(0, 1));
         wr_offset = 2'($urandom); wr_data = {$urandom, $urandom}; wr_be = 8'($urandom);
         fill_start = ($urandom_range(0, 7) == 0); fill_index = 6'($urandom_range(0, 3));
         fill_way = 3'($urandom_range(0, 1));
         fill_valid = 1'($urandom); fill_data = {$urandom, $urandom};
         tick();
      end
      idle();
      for (int i = 0; i < 6; i++) tick();
      for (int w = 0; w < 2; w++) for (int o = 0; o < 4; o++) rd(2, w, o);
      tick(); tick();
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
